ibex_instr_fifo: RTL and testbench
==================================

// Module: ibex_instr_fifo
// PURPOSE
//  Parametrised instruction fetch FIFO between the instruction-bus response path and the ID stage.
//  Buffers fetched 32-bit words and realigns them into 16-bit compressed or 32-bit instructions,
//    including 32-bit instructions that straddle two words.
//  Tracks the current instruction address and reports occupancy and per-request busy status to the prefetch buffer.
//  Adds over the previous generation: RV32C mode switch, out_err_plus2_o, count_o, busy_o, reset address register.
// PARAMETERS
//  NUM_REQS  2  max outstanding bus requests; FIFO depth DEPTH = NUM_REQS+1 words (NUM_REQS>=1)
//  RV32C     1  1: compressed/unaligned support; 0: all instrs 32-bit aligned, addr step 4
// PORTS
//  clk_i             in   1              clock
//  rst_ni            in   1              async active-low reset
//  clear_i           in   1              flush all entries, load in_addr_i as next address
//  in_valid_i        in   1              bus response word valid
//  in_ready_o        out  1              >= NUM_REQS entries free
//  in_addr_i         in   32             restart address, used only with clear_i; bit 0 ignored
//  in_rdata_i        in   32             response word
//  in_err_i          in   1              response bus error
//  busy_o            out  NUM_REQS       busy_o[i] = entry DEPTH-NUM_REQS+i occupied
//  count_o           out  $clog2(DEPTH+1) occupied entries, 0..DEPTH
//  out_valid_o       out  1              complete instruction available
//  out_ready_i       in   1              ID consumes instruction
//  out_addr_o        out  32             instruction address, bit 0 always 0
//  out_rdata_o       out  32             instruction; compressed in [15:0], [31:16] don't-care
//  out_err_o         out  1              fetch error on any word of this instr
//  out_err_plus2_o   out  1              error only on second word of unaligned 32-bit instr
// BEHAVIOUR
//  Reset: valid_q=0, addr_q=0; out_valid_o=0, count_o=0, busy_o=0, in_ready_o=1, out_err*=0.
//  Storage: DEPTH entries {rdata,err}; entry 0 = oldest; valid bits contiguous from entry 0.
//  Bypass: entry 0 empty & in_valid_i -> in_rdata_i presented on output same cycle (0 latency).
//  Push: in_valid_i writes the lowest free entry; push with pop writes lowest free-1 while shifting down.
//  Pop (word retire) on out_valid_o & out_ready_i & (addr[1]=1 | aligned instr uncompressed).
//    Pop shifts all entries down by one.
//  Aligned (addr[1]=0): instr = word0; compressed iff word0[1:0]!=2'b11.
//  Unaligned (RV32C=1, addr[1]=1): compressed iff word0[17:16]!=2'b11; data {word1[15:0],word0[31:16]}.
//    Uncompressed unaligned: valid needs word0 & word1, either of which may be the bypass word.
//  Errors:
//    - aligned: out_err_o=err0.
//    - unaligned compressed: err0.
//    - unaligned uncompressed: err0|err1; out_err_plus2_o=err1&~err0.
//    - out_err_plus2_o=0 otherwise.
//  Erroring instr: out_valid_o asserted with only word0 held if err0=1 (no wait for word1).
//  Addr: on consume addr_q += 2 (compressed) or 4; on clear_i addr_q <= in_addr_i[31:1]; 32-bit wrap.
//  RV32C=0: addr step always 4, in_addr_i[1] forced 0, pop on every consume, out_err_plus2_o tied 0.
//  clear_i: highest priority; next cycle valid_q=0, count_o=0; same-cycle in_valid_i word discarded.
//    Outputs in the clear cycle are still driven from current state.
//  Full: in_ready_o=~valid_q[DEPTH-NUM_REQS]; push with no free entry is illegal, flagged by assertion.
//  Simultaneous push+pop when full (DEPTH entries): legal; count unchanged.
//  Async reset mid-operation: all state to reset values immediately.
// TESTING
//  1 Reset, clear_i with in_addr_i=0x100, push 0x00000013 -> same-cycle out_valid_o=1, out_addr_o=0x100, rdata=0x13.
//  2 Push 0x4501_4501 (two C instrs) -> consume at 0x100 then 0x102; pop only after second; count 1->0.
//  3 clear_i to 0x202, push 0x0001_3xxx then 0xxxxx_0000 -> one 32-bit instr rdata=0x0000_0001...
//      wait: push words 0x00130000,0x00000000 -> out_rdata_o=0x00000013 at 0x202, next addr 0x206.
//  4 Same as 3 with in_err_i=1 on second word only -> out_err_o=1, out_err_plus2_o=1.
//  5 Stall out_ready_i=0, push 3 words (NUM_REQS=2) -> in_ready_o=0 after 2nd, busy_o=2'b11, count_o=3.
//  6 clear_i coincident with push and consume -> next cycle count_o=0, out_valid_o=0, addr = new in_addr_i.
//  RV32C=0 build: 0x4501 word treated as 32-bit, addr step 4.

Source files
------------

// File: rtl/ibex_instr_fifo.sv
// ibex_instr_fifo: fetch FIFO that realigns bus words into compressed/32-bit instructions
module ibex_instr_fifo #(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          RV32C    = 1'b1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [31:0]                           in_addr_i,
    input  logic [31:0]                           in_rdata_i,
    input  logic                                  in_err_i,
    output logic [NUM_REQS-1:0]                   busy_o,
    output logic [$clog2(NUM_REQS+2)-1:0]         count_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [31:0]                           out_addr_o,
    output logic [31:0]                           out_rdata_o,
    output logic                                  out_err_o,
    output logic                                  out_err_plus2_o
);
    localparam int unsigned DEPTH = NUM_REQS + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] valid_q, valid_d, err_q, err_d, vs, wr_en;
    logic [31:0]      rdata_q [DEPTH];
    logic [31:0]      rdata_d [DEPTH];
    logic [31:1]      addr_q;
    logic [31:0]      w0;
    logic [15:0]      w1;
    logic             e0, e1, v0, v1, unaligned, comp, big, pop, push;
    logic             unused_addr;
    assign unused_addr = in_addr_i[0];
    // Word 0 / word 1 come from storage, or straight from the bus when not yet stored
    always_comb begin
        w0        = valid_q[0] ? rdata_q[0] : in_rdata_i;
        e0        = valid_q[0] ? err_q[0] : in_err_i;
        w1        = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
        e1        = valid_q[1] ? err_q[1] : in_err_i;
        v0        = valid_q[0] | in_valid_i;
        v1        = valid_q[1] | (valid_q[0] & in_valid_i);
        unaligned = RV32C & addr_q[1];
        comp      = RV32C & (unaligned ? (w0[17:16] != 2'b11) : (w0[1:0] != 2'b11));
        big       = unaligned & ~comp;
        out_valid_o     = v0 & (~big | v1 | e0);
        out_rdata_o     = unaligned ? {w1, w0[31:16]} : w0;
        out_err_o       = out_valid_o & (e0 | (big & e1));
        out_err_plus2_o = out_valid_o & big & e1 & ~e0;
        out_addr_o      = {addr_q, 1'b0};
        pop             = out_valid_o & out_ready_i & (unaligned | ~comp);
    end
    // Shift on pop, then write the incoming word into the lowest free slot
    always_comb begin
        push  = in_valid_i & ~(pop & ~valid_q[0]);
        vs    = pop ? valid_q >> 1 : valid_q;
        err_d = pop ? err_q >> 1 : err_q;
        for (int i = 0; i < DEPTH; i++) rdata_d[i] = rdata_q[i];
        if (pop)
            for (int i = 0; i < DEPTH - 1; i++) rdata_d[i] = rdata_q[i+1];
        wr_en   = push ? (~vs & (vs + 1'b1)) : '0;
        valid_d = vs | wr_en;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                rdata_d[i] = in_rdata_i;
                err_d[i]   = in_err_i;
            end
        end
    end
    // Occupancy and request-slot status
    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) count_o = count_o + CW'(valid_q[i]);
        busy_o     = valid_q[DEPTH-1:DEPTH-NUM_REQS];
        in_ready_o = ~valid_q[DEPTH-NUM_REQS];
    end
    // Storage and instruction address; clear flushes and reloads the address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            rdata_q <= '{default: '0};
            addr_q  <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
            addr_q  <= {in_addr_i[31:2], in_addr_i[1] & RV32C};
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (out_valid_o & out_ready_i) addr_q <= addr_q + (comp ? 31'd1 : 31'd2);
        end
    end
    // Pushing into a full FIFO without a same-cycle pop loses data
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i && !clear_i && (&valid_q) && !pop));
endmodule

// File: tb/tb_ibex_instr_fifo.sv
// tb_ibex_instr_fifo: randomized queue-model check of the instruction FIFO plus directed cases
module tb_ibex_instr_fifo;
    localparam int D = 3;
    logic clk = 0, rst_n = 0;
    logic clr = 0, iv = 0, er = 0, rdy = 0;
    logic [31:0] ia = 0, id = 0;
    logic in_ready, out_valid, out_err, out_err2;
    logic [1:0] busy, count;
    logic [31:0] out_addr, out_rdata;
    logic c_clr = 0, c_iv = 0, c_rdy = 0;
    logic c_in_ready, c_out_valid, c_out_err, c_out_err2;
    logic [1:0] c_busy, c_count;
    logic [31:0] c_out_addr, c_out_rdata;
    int n_pass = 0, n_tot = 0;
    bit run = 0;
    logic [32:0] mq[$];
    logic [32:0] av[$];
    logic [31:0] maddr = 0, m_d, m_mask;
    bit m_v, m_c, m_e, m_e2, m_pop;

    always #5 clk = ~clk;

    ibex_instr_fifo #(.NUM_REQS(2), .RV32C(1'b1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .in_valid_i(iv), .in_ready_o(in_ready),
        .in_addr_i(ia), .in_rdata_i(id), .in_err_i(er), .busy_o(busy), .count_o(count),
        .out_valid_o(out_valid), .out_ready_i(rdy), .out_addr_o(out_addr), .out_rdata_o(out_rdata),
        .out_err_o(out_err), .out_err_plus2_o(out_err2));

    ibex_instr_fifo #(.NUM_REQS(2), .RV32C(1'b0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(c_clr), .in_valid_i(c_iv), .in_ready_o(c_in_ready),
        .in_addr_i(ia), .in_rdata_i(id), .in_err_i(er), .busy_o(c_busy), .count_o(c_count),
        .out_valid_o(c_out_valid), .out_ready_i(c_rdy), .out_addr_o(c_out_addr), .out_rdata_o(c_out_rdata),
        .out_err_o(c_out_err), .out_err_plus2_o(c_out_err2));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Expected outputs from the words available (stored queue plus any bus word) and the address
    function automatic void eval();
        logic [32:0] w0;
        bit un;
        av = mq;
        if (iv) av.push_back({er, id});
        m_v = 0; m_c = 0; m_e = 0; m_e2 = 0; m_d = 0; m_mask = 32'hffff_ffff;
        un = maddr[1];
        if (av.size() > 0) begin
            w0 = av[0];
            m_c = un ? (w0[17:16] != 2'b11) : (w0[1:0] != 2'b11);
            if (!un) begin m_v = 1; m_d = w0[31:0]; m_e = w0[32]; end
            else if (m_c) begin m_v = 1; m_d = {16'h0, w0[31:16]}; m_e = w0[32]; end
            else if (av.size() > 1) begin
                m_v = 1; m_d = {av[1][15:0], w0[31:16]};
                m_e = w0[32] | av[1][32]; m_e2 = av[1][32] & ~w0[32];
            end else if (w0[32]) begin m_v = 1; m_e = 1; m_d = {16'h0, w0[31:16]}; end
            if (m_c || (un && av.size() < 2)) m_mask = 32'h0000_ffff;
        end
        m_pop = m_v && rdy && (un || !m_c);
    endfunction

    always @(negedge clk) if (run && rst_n) begin
        eval();
        chk("valid", out_valid, m_v);
        chk("addr", out_addr, maddr);
        chk("count", count, mq.size());
        chk("busy", busy, {30'b0, mq.size() >= 3, mq.size() >= 2});
        chk("in_ready", in_ready, mq.size() < 2);
        if (m_v) begin
            chk("rdata", out_rdata & m_mask, m_d & m_mask);
            chk("err", out_err, m_e);
            chk("err_plus2", out_err2, m_e2);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete(); maddr = 0;
        end else if (run) begin
            if (clr) begin
                mq.delete(); maddr = {ia[31:1], 1'b0};
            end else begin
                if (m_v && rdy) maddr = maddr + (m_c ? 32'd2 : 32'd4);
                if (m_pop) void'(av.pop_front());
                mq = av;
            end
        end
    end

    task automatic step(bit c, logic [31:0] a, bit v, logic [31:0] d, bit e, bit r);
        @(posedge clk); #1;
        clr = c; ia = a; iv = v; id = d; er = e; rdy = r;
        @(negedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst valid", out_valid, 0);
        chk("rst count", count, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst err", {out_err, out_err2}, 0);
        rst_n = 1; run = 1;
        step(1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 1, 32'h13, 0, 0);
        chk("t1 valid", out_valid, 1);
        chk("t1 addr", out_addr, 32'h100);
        chk("t1 rdata", out_rdata, 32'h13);
        step(0, 0, 0, 0, 0, 1);
        chk("t1 count", count, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("t1 post count", count, 0);
        chk("t1 post addr", out_addr, 32'h104);
        step(1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 1, 32'h4501_4501, 0, 1);
        chk("t2 addr0", out_addr, 32'h100);
        chk("t2 c0", out_rdata[15:0], 16'h4501);
        step(0, 0, 0, 0, 0, 1);
        chk("t2 count1", count, 1);
        chk("t2 addr1", out_addr, 32'h102);
        chk("t2 c1", out_rdata[15:0], 16'h4501);
        step(0, 0, 0, 0, 0, 0);
        chk("t2 count0", count, 0);
        chk("t2 addr2", out_addr, 32'h104);
        step(1, 32'h202, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0013_0000, 0, 0);
        chk("t3 wait", out_valid, 0);
        step(0, 0, 1, 32'h0000_0000, 0, 1);
        chk("t3 valid", out_valid, 1);
        chk("t3 rdata", out_rdata, 32'h0000_0013);
        chk("t3 addr", out_addr, 32'h202);
        step(0, 0, 0, 0, 0, 0);
        chk("t3 next addr", out_addr, 32'h206);
        step(1, 32'h202, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0013_0000, 0, 0);
        step(0, 0, 1, 32'h0000_0000, 1, 0);
        chk("t4 err", out_err, 1);
        chk("t4 plus2", out_err2, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h13, 0, 0);
        step(0, 0, 1, 32'h13, 0, 0);
        chk("t5 ready1", in_ready, 1);
        step(0, 0, 1, 32'h13, 0, 0);
        chk("t5 ready2", in_ready, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t5 busy", busy, 2'b11);
        chk("t5 count", count, 3);
        step(0, 0, 1, 32'h13, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("full push+pop count", count, 3);
        step(1, 32'h300, 1, 32'h13, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("t6 count", count, 0);
        chk("t6 valid", out_valid, 0);
        chk("t6 addr", out_addr, 32'h300);
        @(posedge clk); #1;
        c_clr = 1; ia = 32'h102;
        @(posedge clk); #1;
        c_clr = 0; c_iv = 1; c_rdy = 1; id = 32'h4501_4501;
        @(negedge clk); #1;
        chk("rv32i valid", c_out_valid, 1);
        chk("rv32i addr", c_out_addr, 32'h100);
        chk("rv32i rdata", c_out_rdata, 32'h4501_4501);
        @(posedge clk); #1;
        c_iv = 0; c_rdy = 0;
        @(negedge clk); #1;
        chk("rv32i count", c_count, 0);
        chk("rv32i addr step", c_out_addr, 32'h104);
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            clr = ($urandom % 30) == 0;
            ia  = $urandom & 32'hffff_fffe;
            id  = $urandom;
            er  = ($urandom % 8) == 0;
            rdy = $urandom % 2;
            iv  = 0;
            eval();
            iv  = (($urandom % 3) != 0) && (clr || mq.size() < D || m_pop);
        end
        @(posedge clk); #1;
        clr = 0; iv = 0; rdy = 0;
        #2 rst_n = 0;
        #1;
        chk("async rst count", count, 0);
        chk("async rst valid", out_valid, 0);
        chk("async rst addr", out_addr, 0);
        rst_n = 1;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
